// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared types for the FP issue stage: operation encoding, the request record
// buffered in the operand FIFO, and a sign-flip helper.
// ----------------------------------------------------------------------------
package fpu_pkg;

   localparam int unsigned FP_SIGN_BIT = 31;
   localparam int unsigned FP_TAG_W    = 5;

   typedef enum logic [1:0] {
      FP_ADD = 2'b00,
      FP_SUB = 2'b01,
      FP_NEG = 2'b10,
      FP_ABS = 2'b11
   } fp_op_t;

   typedef struct packed {
      fp_op_t                op;
      logic [31:0]           x1;
      logic [31:0]           x2;
      logic [FP_TAG_W-1:0]   tag;
   } fp_req_t;

   function automatic logic [31:0] fp_flip_sign(input logic [31:0] x);
      logic [31:0] r;
      r              = x;
      r[FP_SIGN_BIT] = ~x[FP_SIGN_BIT];
      return r;
   endfunction

endpackage

// File: rtl/fadd_issue_stage_if.sv
// ----------------------------------------------------------------------------
// fadd_issue_stage_if
// Bundles the request, adder and result/writeback signals of the FP issue
// stage.
//   slave  : the issue stage itself
//   master : its environment (decoder, combinational adder, writeback)
// Request : in_valid/in_ready, in_op, in_x1, in_x2, in_tag
// Adder   : add_x1/add_x2 out to adder, add_y/add_ovf back
// Result  : out_valid/out_ready, out_y, out_ovf, out_tag
// Status  : ovf_sticky, clr_ovf, count
// ----------------------------------------------------------------------------
interface fadd_issue_stage_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 5
) ();

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_x1;
   logic [31:0]      in_x2;
   logic [TAG_W-1:0] in_tag;

   logic [31:0]      add_x1;
   logic [31:0]      add_x2;
   logic [31:0]      add_y;
   logic             add_ovf;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_y;
   logic             out_ovf;
   logic [TAG_W-1:0] out_tag;

   logic             ovf_sticky;
   logic             clr_ovf;
   logic [CNT_W-1:0] count;

   modport slave (
      input  in_valid, in_op, in_x1, in_x2, in_tag,
      output in_ready,
      output add_x1, add_x2,
      input  add_y, add_ovf,
      output out_valid, out_y, out_ovf, out_tag,
      input  out_ready,
      output ovf_sticky, count,
      input  clr_ovf
   );

   modport master (
      output in_valid, in_op, in_x1, in_x2, in_tag,
      input  in_ready,
      input  add_x1, add_x2,
      output add_y, add_ovf,
      input  out_valid, out_y, out_ovf, out_tag,
      output out_ready,
      input  ovf_sticky, count,
      output clr_ovf
   );

endinterface

// File: rtl/fpu_op_fifo.sv
// ----------------------------------------------------------------------------
// fpu_op_fifo
// Synchronous FIFO of fp_req_t entries. DEPTH must be a power of two so the
// pointers wrap naturally.
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop head entry (ignored when empty)
//   o_data     : head entry
//   o_count    : occupancy, o_full / o_empty derived from it
// ----------------------------------------------------------------------------
module fpu_op_fifo
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  fp_req_t                      i_data,
   input  logic                         i_pop,
   output fp_req_t                      o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fp_req_t         r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fadd_issue_stage.sv
// ----------------------------------------------------------------------------
// fadd_issue_stage
// Buffers FP requests, prepares operands for the external combinational
// adder from the FIFO head (sign of x2 flipped for fsub), computes fneg/fabs
// locally, and registers the result with its tag for writeback.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fadd_issue_stage_if.slave (request, adder, result, status)
// ----------------------------------------------------------------------------
module fadd_issue_stage
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = FP_TAG_W
) (
   input  logic               clk,
   input  logic               rst,
   fadd_issue_stage_if.slave  bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   // The request record in the package carries a fixed-width tag.
   if (TAG_W != FP_TAG_W) begin : g_tag_w_check
      $error("TAG_W must equal fpu_pkg::FP_TAG_W");
   end

   fp_req_t          w_req_in;
   fp_req_t          w_head;
   logic [CW-1:0]    w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_fire;
   logic [31:0]      w_add_x1;
   logic [31:0]      w_add_x2;
   logic [31:0]      w_res_y;
   logic             w_res_ovf;

   logic             r_out_valid;
   logic [31:0]      r_out_y;
   logic             r_out_ovf;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_ovf_sticky;

   assign w_req_in = '{op: fp_op_t'(bus.in_op), x1: bus.in_x1, x2: bus.in_x2, tag: bus.in_tag};

   // No pass-through on full: in_ready depends on registered count only.
   assign w_push = bus.in_valid & ~w_full;
   assign w_fire = ~w_empty & (~r_out_valid | bus.out_ready);

   fpu_op_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_req_in),
      .i_pop   (w_fire),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_add_x1 = '0;
      w_add_x2 = '0;
      if (!w_empty) begin
         w_add_x1 = w_head.x1;
         w_add_x2 = (w_head.op == FP_SUB) ? fp_flip_sign(w_head.x2) : w_head.x2;
      end
   end

   always_comb begin
      w_res_y   = bus.add_y;
      w_res_ovf = bus.add_ovf;
      unique case (w_head.op)
         FP_ADD, FP_SUB: begin
            w_res_y   = bus.add_y;
            w_res_ovf = bus.add_ovf;
         end
         FP_NEG: begin
            w_res_y   = fp_flip_sign(w_head.x1);
            w_res_ovf = 1'b0;
         end
         FP_ABS: begin
            w_res_y   = {1'b0, w_head.x1[FP_SIGN_BIT-1:0]};
            w_res_ovf = 1'b0;
         end
         default: begin
            w_res_y   = bus.add_y;
            w_res_ovf = bus.add_ovf;
         end
      endcase
   end

   // Data fields hold after the result is consumed; only valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_y     <= '0;
         r_out_ovf   <= 1'b0;
         r_out_tag   <= '0;
      end else if (w_fire) begin
         r_out_valid <= 1'b1;
         r_out_y     <= w_res_y;
         r_out_ovf   <= w_res_ovf;
         r_out_tag   <= w_head.tag;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Clear wins over a coincident overflow handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf_sticky <= 1'b0;
      end else if (bus.clr_ovf) begin
         r_ovf_sticky <= 1'b0;
      end else if (r_out_valid && bus.out_ready && r_out_ovf) begin
         r_ovf_sticky <= 1'b1;
      end
   end

   assign bus.in_ready   = ~w_full;
   assign bus.add_x1     = w_add_x1;
   assign bus.add_x2     = w_add_x2;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_y      = r_out_y;
   assign bus.out_ovf    = r_out_ovf;
   assign bus.out_tag    = r_out_tag;
   assign bus.ovf_sticky = r_ovf_sticky;
   assign bus.count      = w_count;

endmodule

// File: tb/tb_fadd_issue_stage.sv
// ----------------------------------------------------------------------------
// tb_fadd_issue_stage
// Directed scenarios plus a randomized phase. A negedge monitor keeps an
// in-order queue of expected results and a sticky-overflow model.
// ----------------------------------------------------------------------------
module tb_fadd_issue_stage;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fadd_issue_stage_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

   fadd_issue_stage #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Stand-in adder: exact values for the directed cases, a scramble otherwise.
   function automatic logic [32:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
      if (a == 32'h4040_0000 && b == 32'hBF80_0000) return {1'b0, 32'h4000_0000};
      if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {1'b1, 32'h7F80_0000};
      return {(a[3:0] == 4'hF), (a + b) ^ 32'h5A5A_0000};
   endfunction

   assign {bus.add_ovf, bus.add_y} = adder_fn(bus.add_x1, bus.add_x2);

   typedef struct {
      logic [31:0]      y;
      logic             ovf;
      logic [TAG_W-1:0] tag;
   } exp_t;

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] x1,
                                  input logic [31:0] x2, input logic [TAG_W-1:0] tag);
      exp_t        e;
      logic [32:0] r;
      case (op)
         2'd0:    r = adder_fn(x1, x2);
         2'd1:    r = adder_fn(x1, x2 ^ 32'h8000_0000);
         2'd2:    r = {1'b0, x1 ^ 32'h8000_0000};
         default: r = {1'b0, x1 & 32'h7FFF_FFFF};
      endcase
      e.y   = r[31:0];
      e.ovf = r[32];
      e.tag = tag;
      return e;
   endfunction

   exp_t exp_q[$];
   exp_t m_e;
   logic m_sticky = 1'b0;
   logic m_hs_ovf;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_sticky = 1'b0;
      end else begin
         m_hs_ovf = 1'b0;
         check_eq("ovf_sticky", {63'd0, bus.ovf_sticky}, {63'd0, m_sticky});
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_out_valid", {63'd0, bus.out_valid}, 64'd0);
            end else begin
               m_e = exp_q.pop_front();
               check_eq("out_y", {32'd0, bus.out_y}, {32'd0, m_e.y});
               check_eq("out_ovf", {63'd0, bus.out_ovf}, {63'd0, m_e.ovf});
               check_eq("out_tag", 64'(bus.out_tag), 64'(m_e.tag));
               m_hs_ovf = m_e.ovf;
            end
         end
         m_sticky = bus.clr_ovf ? 1'b0 : (m_sticky | m_hs_ovf);
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.in_op, bus.in_x1, bus.in_x2, bus.in_tag));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [TAG_W-1:0] tag);
      logic done;
      done         = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_x1    = x1;
      bus.in_x2    = x2;
      bus.in_tag   = tag;
      for (int i = 0; i < 50 && !done; i++) begin
         done = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
      check_eq("send_accepted", {63'd0, done}, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int   n_acc;
   logic acc;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_op     = 2'd0;
      bus.in_x1     = '0;
      bus.in_x2     = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      bus.clr_ovf   = 1'b0;

      // Reset state
      tick();
      check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check_eq("rst_out_y", {32'd0, bus.out_y}, 64'd0);
      check_eq("rst_count", 64'(bus.count), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check_eq("rst_sticky", {63'd0, bus.ovf_sticky}, 64'd0);

      // 1: fadd latency
      send(2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3);
      check_eq("t1_valid_early", {63'd0, bus.out_valid}, 64'd0);
      check_eq("t1_count", 64'(bus.count), 64'd1);
      tick();
      check_eq("t1_valid", {63'd0, bus.out_valid}, 64'd1);
      check_eq("t1_y", {32'd0, bus.out_y}, 64'h4040_0000);
      check_eq("t1_tag", 64'(bus.out_tag), 64'd3);
      check_eq("t1_ovf", {63'd0, bus.out_ovf}, 64'd0);
      tick();
      check_eq("t1_valid_drop", {63'd0, bus.out_valid}, 64'd0);

      // 2: fsub, fneg, fabs back-to-back
      send(2'd1, 32'h4040_0000, 32'h3F80_0000, 5'd1);
      check_eq("t2_add_x1", {32'd0, bus.add_x1}, 64'h4040_0000);
      check_eq("t2_add_x2", {32'd0, bus.add_x2}, 64'hBF80_0000);
      send(2'd2, 32'h3F80_0000, 32'h1234_5678, 5'd2);
      send(2'd3, 32'hC000_0000, 32'h8765_4321, 5'd3);
      check_eq("t2_neg_tag", 64'(bus.out_tag), 64'd2);
      check_eq("t2_neg_y", {32'd0, bus.out_y}, 64'hBF80_0000);
      tick();
      check_eq("t2_abs_tag", 64'(bus.out_tag), 64'd3);
      check_eq("t2_abs_y", {32'd0, bus.out_y}, 64'h4000_0000);
      tick();

      // 3: stall capacity DEPTH+1, then consecutive drain
      bus.out_ready = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 10; c++) begin
         if (n_acc < 6) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 2'd0;
            bus.in_x1    = $urandom;
            bus.in_x2    = $urandom;
            bus.in_tag   = TAG_W'(n_acc);
         end
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) n_acc++;
      end
      bus.in_valid = 1'b0;
      check_eq("t3_accepted", 64'(n_acc), 64'd5);
      check_eq("t3_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check_eq("t3_count", 64'(bus.count), 64'd4);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check_eq("t3_drain_valid", {63'd0, bus.out_valid}, 64'd1);
         tick();
      end
      check_eq("t3_drained", {63'd0, bus.out_valid}, 64'd0);
      check_eq("t3_in_ready_after", {63'd0, bus.in_ready}, 64'd1);

      // 4: overflow sticky
      send(2'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd7);
      tick();
      check_eq("t4_out_ovf", {63'd0, bus.out_ovf}, 64'd1);
      check_eq("t4_sticky_pre", {63'd0, bus.ovf_sticky}, 64'd0);
      tick();
      check_eq("t4_sticky_set", {63'd0, bus.ovf_sticky}, 64'd1);
      send(2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd8);
      tick();
      tick();
      check_eq("t4_sticky_hold", {63'd0, bus.ovf_sticky}, 64'd1);
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      check_eq("t4_sticky_clr", {63'd0, bus.ovf_sticky}, 64'd0);
      bus.out_ready = 1'b0;
      send(2'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd9);
      tick();
      check_eq("t4_held_ovf", {63'd0, bus.out_ovf}, 64'd1);
      bus.out_ready = 1'b1;
      bus.clr_ovf   = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      check_eq("t4_clr_priority", {63'd0, bus.ovf_sticky}, 64'd0);
      check_eq("t4_valid_drop", {63'd0, bus.out_valid}, 64'd0);

      // 5: full FIFO, no push in the pop cycle
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int c = 0; c < 8; c++) begin
         bus.in_op  = 2'd0;
         bus.in_x1  = $urandom;
         bus.in_x2  = $urandom;
         bus.in_tag = TAG_W'($urandom);
         tick();
      end
      for (int s = 0; s < 6; s++) begin
         check_eq("t5_count_seq", 64'(bus.count), (s % 2 == 0) ? 64'd4 : 64'd3);
         bus.out_ready = (s % 2 == 0);
         bus.in_x1     = $urandom;
         bus.in_x2     = $urandom;
         bus.in_tag    = TAG_W'($urandom);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) tick();
      check_eq("t5_count_end", 64'(bus.count), 64'd0);

      // 6: asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(2'd0, $urandom, $urandom, TAG_W'(20 + i));
      check_eq("t6_pre_count", 64'(bus.count), 64'd3);
      check_eq("t6_pre_valid", {63'd0, bus.out_valid}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_count", 64'(bus.count), 64'd0);
      check_eq("t6_valid", {63'd0, bus.out_valid}, 64'd0);
      check_eq("t6_out_y", {32'd0, bus.out_y}, 64'd0);
      check_eq("t6_out_tag", 64'(bus.out_tag), 64'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check_eq("t6_no_stale", {63'd0, bus.out_valid}, 64'd0);
      check_eq("t6_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Randomized traffic
      for (int c = 0; c < 300; c++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_op     = 2'($urandom_range(0, 3));
         bus.in_x1     = $urandom;
         bus.in_x2     = $urandom;
         bus.in_tag    = TAG_W'($urandom);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         bus.clr_ovf   = ($urandom_range(0, 19) == 0);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.clr_ovf   = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
      check_eq("rand_drain_empty", 64'(exp_q.size()), 64'd0);
      check_eq("rand_final_valid", {63'd0, bus.out_valid}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
